mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Data-side bus responder: the target end of the CPU's load/store port.
- Accepts one read/write request at a time over a valid/ready handshake and inserts a configurable number of wait states.
- Returns read data or status over a second valid/ready handshake.
- Decodes a word RAM plus a small memory-mapped I/O window (switches, LED register, cycle counter). Sits between the core's load/store unit and memory/board I/O.

Parameters:
- DEPTH, 128, RAM size in 32-bit words; word index = addr[31:2] must be < DEPTH.
- WAIT_STATES, 2, idle cycles between request acceptance and commit; 0 allowed.
- IO_BASE, 32'h0000_0400, byte address of the I/O window; must be above RAM space.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1=write, 0=read.
- req_addr  in  32  byte address.
- req_wdata  in  32  write data.
- req_be  in  4  byte enables for writes; bit i covers bits [8i+7:8i].
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester accepts response.
- rsp_rdata  out  32  read data; 0 for writes and errors.
- rsp_err  out  1  unmapped or misaligned access.
- sw_in  in  10  board switches.
- led_out  out  32  LED register.

Behaviour:
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, led_out=0, cycle counter=0, wait counter=0. RAM array is not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid&req_ready, latch we/addr/wdata/be.
  - WAIT_STATES>0: go to WAIT and load the wait counter with WAIT_STATES-1.
  - WAIT_STATES=0: commit on this same edge and go to RESP.
- WAIT: req_ready=0. Decrement the counter each cycle. On the edge where the counter is 0, commit and go to RESP.
- Commit edge:
  - Read: registers rsp_rdata.
  - Write: updates the target under req_be.
  - rsp_err is registered on this edge.
- Request-accept-to-rsp_valid latency: WAIT_STATES+1 cycles.
- RESP: rsp_valid=1. rsp_rdata and rsp_err are held stable until rsp_valid&rsp_ready, then go to IDLE. A new request is accepted on the cycle after the response handshake, never in the same cycle.
- Address decode:
  - addr[1:0]!=0: error, no write, rdata=0.
  - addr[31:2]<DEPTH: RAM.
  - IO_BASE+0x0: switches, read-only; reads {22'b0, sw_in} sampled at the commit edge; writes are ignored, no error.
  - IO_BASE+0x4: LED register, read/write with byte enables.
  - IO_BASE+0x8: cycle counter, read-only; reads return the counter value before the commit-edge increment; writes are ignored.
  - Anything else: rsp_err=1, rdata=0.
- req_be ignored on reads (full word returned). Write with req_be=0 is a legal no-op, no error.
- Cycle counter: 32-bit, increments every clk while reset is low, wraps 32'hFFFF_FFFF -> 0.
- Reset mid-operation (WAIT or RESP): abort immediately. An uncommitted write is never performed. Return to IDLE with reset values. RAM keeps prior contents.
- req_valid while not ready: ignored. The requester holds the request; no queuing.

Optional Feature:
- Macro: CYCLE_COUNTER_EN.
- Defined: counter present; IO_BASE+0x8 behaves as above.
- Undefined: no counter logic; IO_BASE+0x8 decodes as unmapped (rsp_err=1, rdata=0).

Test Plan:
- WAIT_STATES=2: write 0x0000_0019 to 0x64 with be=4'hF, then read 0x64 -> rsp_valid 3 cycles after each accept; read rdata=0x0000_0019, err=0.
- Byte-enable merge: RAM[0x10]=0xAABBCCDD, write 0x11223344 with be=4'b0101 -> read returns 0xAA22CC44.
- I/O window:
  - sw_in=10'h2A5, read IO_BASE -> rdata=0x0000_02A5.
  - Write 0x0000_00FF to IO_BASE+4 -> led_out=0x0000_00FF after the commit edge.
  - Read IO_BASE+4 -> 0x0000_00FF.
- Errors:
  - Read 0x66 (misaligned) -> err=1, rdata=0.
  - Write to 0x0000_0800 -> err=1, no state change.
  - With CYCLE_COUNTER_EN undefined, read IO_BASE+8 -> err=1.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rdata stable, req_ready=0, new req_valid not accepted; release -> IDLE next cycle.
- Reset mid-WAIT during a write of 0xDEADBEEF to 0x20 (old 0x1234) -> rsp_valid=0, req_ready=1 immediately; subsequent read of 0x20 returns 0x0000_1234.

Source files
------------

// File: rtl/mem_responder_if.sv
// rtl/mem_responder_if.sv - request/response handshake bundle between the load/store unit and mem_responder
interface mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - wait-stated data-bus target: word RAM plus switch/LED/cycle-counter I/O window
// Optional cycle counter at IO_BASE+8 is built only when CYCLE_COUNTER_EN is defined.
module mem_responder #(
    parameter int          DEPTH       = 128,
    parameter int          WAIT_STATES = 2,
    parameter logic [31:0] IO_BASE     = 32'h0000_0400
) (
    input  logic           clk,
    input  logic           reset,
    mem_responder_if.slave bus,
    input  logic [9:0]     sw_in,
    output logic [31:0]    led_out
);
    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int WCW = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t         state, state_next;
    logic [WCW-1:0] wait_cnt;
    logic           lat_we;
    logic [31:0]    lat_addr, lat_wdata;
    logic [3:0]     lat_be;
    logic [31:0]    rdata_q;
    logic           err_q;
    logic [31:0]    led_q;
    logic [31:0]    ram [DEPTH];
    logic           accept, commit;

    logic           c_we;
    logic [31:0]    c_addr, c_wdata;
    logic [3:0]     c_be;
    logic [31:0]    word_idx;
    logic           hit_ram, hit_sw, hit_led, hit_cnt, c_err;
    logic [31:0]    rd_word;

`ifdef CYCLE_COUNTER_EN
    logic [31:0]    cycle_cnt;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next    = state;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        accept        = 1'b0;
        commit        = 1'b0;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    accept = 1'b1;
                    if (WAIT_STATES == 0) begin
                        commit     = 1'b1;
                        state_next = RESP;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (wait_cnt == '0) begin
                    commit     = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Zero-wait commits happen on the accept edge, so they must use the live request.
    assign c_we    = (state == IDLE) ? bus.req_we    : lat_we;
    assign c_addr  = (state == IDLE) ? bus.req_addr  : lat_addr;
    assign c_wdata = (state == IDLE) ? bus.req_wdata : lat_wdata;
    assign c_be    = (state == IDLE) ? bus.req_be    : lat_be;

    always_comb begin
        word_idx = {2'b00, c_addr[31:2]};
        hit_ram  = (c_addr[1:0] == 2'b00) && (word_idx < 32'(DEPTH));
        hit_sw   = (c_addr == IO_BASE);
        hit_led  = (c_addr == IO_BASE + 32'd4);
`ifdef CYCLE_COUNTER_EN
        hit_cnt  = (c_addr == IO_BASE + 32'd8);
`else
        hit_cnt  = 1'b0;
`endif
        c_err    = !(hit_ram || hit_sw || hit_led || hit_cnt);
        rd_word  = 32'h0;
        if (!c_we) begin
            if (hit_ram)      rd_word = ram[c_addr[AW+1:2]];
            else if (hit_sw)  rd_word = {22'b0, sw_in};
            else if (hit_led) rd_word = led_q;
`ifdef CYCLE_COUNTER_EN
            else if (hit_cnt) rd_word = cycle_cnt;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt  <= '0;
            lat_we    <= 1'b0;
            lat_addr  <= 32'h0;
            lat_wdata <= 32'h0;
            lat_be    <= 4'h0;
            rdata_q   <= 32'h0;
            err_q     <= 1'b0;
            led_q     <= 32'h0;
        end else begin
            if (accept) begin
                lat_we    <= bus.req_we;
                lat_addr  <= bus.req_addr;
                lat_wdata <= bus.req_wdata;
                lat_be    <= bus.req_be;
                wait_cnt  <= WCW'(WAIT_STATES - 1);
            end else if (state == WAIT && wait_cnt != '0) begin
                wait_cnt <= wait_cnt - 1'b1;
            end
            if (commit) begin
                rdata_q <= rd_word;
                err_q   <= c_err;
                if (c_we && hit_led) begin
                    for (int i = 0; i < 4; i++)
                        if (c_be[i]) led_q[8*i +: 8] <= c_wdata[8*i +: 8];
                end
            end
        end
    end

    // RAM has no reset; the reset gate keeps a zero-wait commit from writing during reset.
    always_ff @(posedge clk) begin
        if (commit && c_we && hit_ram && !reset) begin
            for (int i = 0; i < 4; i++)
                if (c_be[i]) ram[c_addr[AW+1:2]][8*i +: 8] <= c_wdata[8*i +: 8];
        end
    end

`ifdef CYCLE_COUNTER_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cycle_cnt <= 32'h0;
        else       cycle_cnt <= cycle_cnt + 32'd1;
    end
`endif

    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
    assign led_out       = led_q;
endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - table-driven scoreboard bench for mem_responder
module tb_mem_responder;
    localparam int          WS  = 2;
    localparam logic [31:0] IOB = 32'h0000_0400;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  sw_in;
    logic [31:0] led_out;

    mem_responder_if bus ();

    mem_responder #(.DEPTH(128), .WAIT_STATES(WS), .IO_BASE(IOB)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .sw_in   (sw_in),
        .led_out (led_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [9:0]  sw;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic [31:0] exp_led;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        chk_rd;
    } rsp_t;

    vec_t vecs[$];
    rsp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        check(name, {31'b0, act}, {31'b0, exp});
    endtask

    task automatic add(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input logic [9:0] sw, input logic [31:0] erd,
                       input logic eerr, input logic [31:0] eled);
        vecs.push_back(vec_t'{we, addr, wdata, be, sw, erd, eerr, eled});
    endtask

    // Called at a negedge; returns just after the accepting posedge.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input logic [31:0] erd, input logic eerr,
                         input logic chk_rd);
        int n = 0;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_be    = be;
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check1("req_ready before accept", bus.req_ready, 1'b1);
        @(posedge clk);
        sb.push_back(rsp_t'{erd, eerr, chk_rd});
        #1 bus.req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag);
        int lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) check1({tag, " req_ready in WAIT"}, bus.req_ready, 1'b0);
        end while (!bus.rsp_valid && lat < 50);
        check({tag, " latency"}, 32'(lat), 32'(WS + 1));
    endtask

    task automatic compare_rsp(input string tag);
        rsp_t e;
        tests++;
        if (sb.size() == 0) begin
            fails++;
            $display("FAIL %s scoreboard: got empty queue expected an entry", tag);
        end else begin
            e = sb.pop_front();
            if (e.chk_rd) check({tag, " rdata"}, bus.rsp_rdata, e.rdata);
            check1({tag, " err"}, bus.rsp_err, e.err);
        end
    endtask

    task automatic finish_rsp(input string tag);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
        @(negedge clk);
        check1({tag, " idle req_ready"}, bus.req_ready, 1'b1);
        check1({tag, " idle rsp_valid"}, bus.rsp_valid, 1'b0);
    endtask

    task automatic xact(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        input logic [31:0] erd, input logic eerr, input logic chk_rd);
        issue(we, addr, wdata, be, erd, eerr, chk_rd);
        wait_rsp(tag);
        compare_rsp(tag);
        finish_rsp(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        add(1'b1, 32'h64,       32'h0000_0019, 4'hF, 10'h000, 32'h0,         1'b0, 32'h0);
        add(1'b0, 32'h64,       32'h0,         4'hF, 10'h000, 32'h0000_0019, 1'b0, 32'h0);
        add(1'b1, 32'h40,       32'hAABB_CCDD, 4'hF, 10'h000, 32'h0,         1'b0, 32'h0);
        add(1'b1, 32'h40,       32'h1122_3344, 4'h5, 10'h000, 32'h0,         1'b0, 32'h0);
        add(1'b0, 32'h40,       32'h0,         4'h0, 10'h000, 32'hAA22_CC44, 1'b0, 32'h0);
        add(1'b0, IOB,          32'h0,         4'hF, 10'h2A5, 32'h0000_02A5, 1'b0, 32'h0);
        add(1'b1, IOB + 32'h4,  32'h0000_00FF, 4'hF, 10'h2A5, 32'h0,         1'b0, 32'h0000_00FF);
        add(1'b0, IOB + 32'h4,  32'h0,         4'hF, 10'h2A5, 32'h0000_00FF, 1'b0, 32'h0000_00FF);
        add(1'b1, IOB + 32'h4,  32'h1234_5600, 4'h2, 10'h2A5, 32'h0,         1'b0, 32'h0000_56FF);
        add(1'b0, IOB + 32'h4,  32'h0,         4'hF, 10'h2A5, 32'h0000_56FF, 1'b0, 32'h0000_56FF);
        add(1'b0, 32'h66,       32'h0,         4'hF, 10'h2A5, 32'h0,         1'b1, 32'h0000_56FF);
        add(1'b1, 32'h42,       32'hFFFF_FFFF, 4'hF, 10'h2A5, 32'h0,         1'b1, 32'h0000_56FF);
        add(1'b1, 32'h800,      32'hFFFF_FFFF, 4'hF, 10'h2A5, 32'h0,         1'b1, 32'h0000_56FF);
        add(1'b0, 32'h40,       32'h0,         4'hF, 10'h2A5, 32'hAA22_CC44, 1'b0, 32'h0000_56FF);
        add(1'b1, 32'h64,       32'hFFFF_FFFF, 4'h0, 10'h2A5, 32'h0,         1'b0, 32'h0000_56FF);
        add(1'b0, 32'h64,       32'h0,         4'hF, 10'h2A5, 32'h0000_0019, 1'b0, 32'h0000_56FF);
        add(1'b1, IOB,          32'hFFFF_FFFF, 4'hF, 10'h2A5, 32'h0,         1'b0, 32'h0000_56FF);
        add(1'b0, IOB,          32'h0,         4'hF, 10'h155, 32'h0000_0155, 1'b0, 32'h0000_56FF);
        add(1'b1, 32'h1FC,      32'hCAFE_F00D, 4'hF, 10'h155, 32'h0,         1'b0, 32'h0000_56FF);
        add(1'b0, 32'h1FC,      32'h0,         4'hF, 10'h155, 32'hCAFE_F00D, 1'b0, 32'h0000_56FF);
        add(1'b0, 32'h200,      32'h0,         4'hF, 10'h155, 32'h0,         1'b1, 32'h0000_56FF);
        add(1'b0, IOB + 32'hC,  32'h0,         4'hF, 10'h155, 32'h0,         1'b1, 32'h0000_56FF);
        add(1'b1, 32'h20,       32'h0000_1234, 4'hF, 10'h155, 32'h0,         1'b0, 32'h0000_56FF);

        reset         = 1'b1;
        sw_in         = 10'h0;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = 32'h0;
        bus.req_wdata = 32'h0;
        bus.req_be    = 4'h0;
        bus.rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        check1("reset req_ready", bus.req_ready, 1'b1);
        check1("reset rsp_valid", bus.rsp_valid, 1'b0);
        check("reset rsp_rdata", bus.rsp_rdata, 32'h0);
        check1("reset rsp_err", bus.rsp_err, 1'b0);
        check("reset led_out", led_out, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            sw_in = vecs[i].sw;
            xact(tag, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be,
                 vecs[i].exp_rdata, vecs[i].exp_err, 1'b1);
            check({tag, " led_out"}, led_out, vecs[i].exp_led);
        end

`ifdef CYCLE_COUNTER_EN
        xact("cnt", 1'b0, IOB + 32'h8, 32'h0, 4'hF, 32'h0, 1'b0, 1'b0);
`else
        xact("cnt", 1'b0, IOB + 32'h8, 32'h0, 4'hF, 32'h0, 1'b1, 1'b1);
`endif

        // Backpressure: response must hold while a competing request waits.
        issue(1'b0, 32'h64, 32'h0, 4'hF, 32'h0000_0019, 1'b0, 1'b1);
        wait_rsp("bp");
        compare_rsp("bp");
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 32'h40;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            check1($sformatf("bp hold%0d rsp_valid", k), bus.rsp_valid, 1'b1);
            check($sformatf("bp hold%0d rdata", k), bus.rsp_rdata, 32'h0000_0019);
            check1($sformatf("bp hold%0d req_ready", k), bus.req_ready, 1'b0);
        end
        bus.req_valid = 1'b0;
        finish_rsp("bp");

        // Reset during WAIT must drop the pending write.
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 32'h20;
        bus.req_wdata = 32'hDEAD_BEEF;
        bus.req_be    = 4'hF;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check1("rst rsp_valid", bus.rsp_valid, 1'b0);
        check1("rst req_ready", bus.req_ready, 1'b1);
        check("rst led_out", led_out, 32'h0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        xact("rst read", 1'b0, 32'h20, 32'h0, 4'hF, 32'h0000_1234, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
